// File: rtl/parking_pkg.sv
// Shared definitions for the parking entry controller: FSM encodings,
// default PIN and the occupancy width helper.
package parking_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE      = 2'd0;
    localparam logic [STATE_W-1:0] PIN_ENTRY = 2'd1;
    localparam logic [STATE_W-1:0] GATE_OPEN = 2'd2;
    localparam logic [STATE_W-1:0] BLOCKED   = 2'd3;

    localparam int unsigned DEFAULT_PIN = 87;

    // Bits needed to hold 0..cap inclusive.
    function automatic int unsigned occ_w(input int unsigned cap);
        return $clog2(cap + 1);
    endfunction

endpackage

// File: rtl/parking_occupancy_ctr.sv
// Saturating lot occupancy counter with a registered full flag.
module parking_occupancy_ctr
    import parking_pkg::*;
#(
    parameter int unsigned CAPACITY = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inc,
    input  logic                          dec,
    output logic [occ_w(CAPACITY)-1:0]    occupancy,
    output logic                          lot_full
);

    localparam int unsigned OCC_W = occ_w(CAPACITY);

    logic [OCC_W-1:0] occ_d, occ_q;
    logic             full_d, full_q;

    // Simultaneous entry and exit cancel out.
    always_comb begin
        occ_d = occ_q;
        if (inc && !dec && occ_q != OCC_W'(CAPACITY)) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (dec && !inc && occ_q != '0) begin
            occ_d = occ_q - OCC_W'(1);
        end
        full_d = (occ_d == OCC_W'(CAPACITY));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            full_q <= full_d;
        end
    end

    assign occupancy = occ_q;
    assign lot_full  = full_q;

endmodule

// File: rtl/parking_gate_ctrl_param.sv
// PIN-authorised parking entry gate with attempt limit, open timeout,
// tailgate blocking and lot occupancy tracking.
module parking_gate_ctrl_param
    import parking_pkg::*;
#(
    parameter int unsigned         PIN_W     = 8,
    parameter logic [PIN_W-1:0]    PIN_VAL   = PIN_W'(DEFAULT_PIN),
    parameter int unsigned         MAX_TRIES = 3,
    parameter int unsigned         CAPACITY  = 16,
    parameter int unsigned         OPEN_TO   = 200
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sensor_1,
    input  logic                          sensor_2,
    input  logic                          try_psswrd,
    input  logic [PIN_W-1:0]              psswrd_atmpt,
    input  logic                          car_exit,
    output logic                          alarm_1,
    output logic                          alarm_2,
    output logic                          open_gate,
    output logic                          close_gate,
    output logic                          lot_full,
    output logic [occ_w(CAPACITY)-1:0]    occupancy
);

    localparam int unsigned ATT_W = $clog2(MAX_TRIES + 1);
    localparam int unsigned TO_W  = $clog2(OPEN_TO);

    logic [STATE_W-1:0] state_d, state_q;
    logic [ATT_W-1:0]   attempts_d, attempts_q;
    logic [TO_W-1:0]    timeout_d, timeout_q;
    logic               alarm_1_d, alarm_1_q;
    logic               alarm_2_d, alarm_2_q;
    logic               open_gate_d, open_gate_q;
    logic               close_gate_d, close_gate_q;
    logic               occ_inc;
    logic               pin_ok;
    logic               lot_full_w;

    assign pin_ok = try_psswrd && (psswrd_atmpt == PIN_VAL);

    // Next state and next registered outputs.
    always_comb begin
        state_d      = state_q;
        attempts_d   = attempts_q;
        timeout_d    = timeout_q;
        alarm_1_d    = alarm_1_q;
        alarm_2_d    = alarm_2_q;
        open_gate_d  = open_gate_q;
        close_gate_d = 1'b0;
        occ_inc      = 1'b0;

        if (state_q != BLOCKED && sensor_1 && sensor_2) begin
            state_d     = BLOCKED;
            alarm_2_d   = 1'b1;
            open_gate_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sensor_1 && !lot_full_w) begin
                        state_d = PIN_ENTRY;
                    end
                end
                PIN_ENTRY: begin
                    if (pin_ok) begin
                        state_d     = GATE_OPEN;
                        open_gate_d = 1'b1;
                        attempts_d  = '0;
                        alarm_1_d   = 1'b0;
                        timeout_d   = '0;
                    end else if (try_psswrd) begin
                        if (attempts_q != ATT_W'(MAX_TRIES)) begin
                            attempts_d = attempts_q + ATT_W'(1);
                        end
                        if (attempts_d == ATT_W'(MAX_TRIES)) begin
                            alarm_1_d = 1'b1;
                        end
                    end
                end
                GATE_OPEN: begin
                    if (sensor_2 || timeout_q == TO_W'(OPEN_TO - 1)) begin
                        state_d      = IDLE;
                        open_gate_d  = 1'b0;
                        close_gate_d = 1'b1;
                        occ_inc      = sensor_2;
                        timeout_d    = '0;
                    end else begin
                        timeout_d = timeout_q + TO_W'(1);
                    end
                end
                BLOCKED: begin
                    if (pin_ok) begin
                        state_d    = IDLE;
                        alarm_2_d  = 1'b0;
                        alarm_1_d  = 1'b0;
                        attempts_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            attempts_q   <= '0;
            timeout_q    <= '0;
            alarm_1_q    <= 1'b0;
            alarm_2_q    <= 1'b0;
            open_gate_q  <= 1'b0;
            close_gate_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            attempts_q   <= attempts_d;
            timeout_q    <= timeout_d;
            alarm_1_q    <= alarm_1_d;
            alarm_2_q    <= alarm_2_d;
            open_gate_q  <= open_gate_d;
            close_gate_q <= close_gate_d;
        end
    end

    parking_occupancy_ctr #(
        .CAPACITY (CAPACITY)
    ) u_occ (
        .clk       (clk),
        .rst       (rst),
        .inc       (occ_inc),
        .dec       (car_exit),
        .occupancy (occupancy),
        .lot_full  (lot_full_w)
    );

    assign alarm_1    = alarm_1_q;
    assign alarm_2    = alarm_2_q;
    assign open_gate  = open_gate_q;
    assign close_gate = close_gate_q;
    assign lot_full   = lot_full_w;

endmodule

// File: tb/tb_parking_gate_ctrl_param.sv
// Directed bench for parking_gate_ctrl_param (CAPACITY=2, OPEN_TO=8).
module tb_parking_gate_ctrl_param;

    localparam int unsigned CAP  = 2;
    localparam int unsigned OTO  = 8;
    localparam int unsigned PIN  = 87;
    localparam int unsigned BADP = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor_1, sensor_2, try_psswrd, car_exit;
    logic [7:0] psswrd_atmpt;
    logic       alarm_1, alarm_2, open_gate, close_gate, lot_full;
    logic [1:0] occupancy;

    int n_cmp = 0;
    int n_err = 0;

    parking_gate_ctrl_param #(
        .PIN_W     (8),
        .PIN_VAL   (8'd87),
        .MAX_TRIES (3),
        .CAPACITY  (CAP),
        .OPEN_TO   (OTO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor_1     (sensor_1),
        .sensor_2     (sensor_2),
        .try_psswrd   (try_psswrd),
        .psswrd_atmpt (psswrd_atmpt),
        .car_exit     (car_exit),
        .alarm_1      (alarm_1),
        .alarm_2      (alarm_2),
        .open_gate    (open_gate),
        .close_gate   (close_gate),
        .lot_full     (lot_full),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs settle 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic try_pin(input int unsigned val);
        psswrd_atmpt = 8'(val);
        try_psswrd   = 1'b1;
        tick();
        try_psswrd   = 1'b0;
    endtask

    task automatic enter_pin_entry();
        sensor_1 = 1'b1;
        tick();
        sensor_1 = 1'b0;
    endtask

    task automatic admit_car();
        enter_pin_entry();
        try_pin(PIN);
        sensor_2 = 1'b1;
        tick();
        sensor_2 = 1'b0;
    endtask

    initial begin
        int open_cnt;
        rst = 1'b1; sensor_1 = 1'b0; sensor_2 = 1'b0;
        try_psswrd = 1'b0; car_exit = 1'b0; psswrd_atmpt = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_alarm_1", alarm_1, 0);
        check("rst_alarm_2", alarm_2, 0);
        check("rst_open", open_gate, 0);
        check("rst_close", close_gate, 0);
        check("rst_full", lot_full, 0);
        check("rst_occ", occupancy, 0);

        // Normal entry; dropping sensor_1 during PIN entry does not abort.
        enter_pin_entry();
        try_pin(PIN);
        check("entry_open", open_gate, 1);
        check("entry_close_low", close_gate, 0);
        sensor_2 = 1'b1;
        tick();
        sensor_2 = 1'b0;
        check("pass_close", close_gate, 1);
        check("pass_open", open_gate, 0);
        check("pass_occ", occupancy, 1);
        tick();
        check("pass_close_pulse", close_gate, 0);

        // Wrong PIN attempts up to and past the limit.
        enter_pin_entry();
        try_pin(BADP);
        check("bad1_alarm_1", alarm_1, 0);
        try_pin(BADP);
        check("bad2_alarm_1", alarm_1, 0);
        try_pin(BADP);
        check("bad3_alarm_1", alarm_1, 1);
        try_pin(BADP);
        check("bad4_alarm_1", alarm_1, 1);
        try_pin(PIN);
        check("good_alarm_1", alarm_1, 0);
        check("good_open", open_gate, 1);

        // Tailgate while open: blocked until correct PIN.
        sensor_1 = 1'b1; sensor_2 = 1'b1;
        tick();
        sensor_1 = 1'b0; sensor_2 = 1'b0;
        check("blk_alarm_2", alarm_2, 1);
        check("blk_open", open_gate, 0);
        check("blk_occ", occupancy, 1);
        try_pin(BADP);
        check("blk_bad_alarm_2", alarm_2, 1);
        try_pin(PIN);
        check("unblk_alarm_2", alarm_2, 0);
        check("unblk_alarm_1", alarm_1, 0);
        check("unblk_occ", occupancy, 1);
        check("unblk_open", open_gate, 0);

        // Timeout: gate open exactly OPEN_TO cycles, then one close pulse.
        enter_pin_entry();
        try_pin(PIN);
        open_cnt = 0;
        while (open_gate && open_cnt < 50) begin
            open_cnt++;
            tick();
        end
        check("to_open_cycles", open_cnt, OTO);
        check("to_close", close_gate, 1);
        check("to_occ", occupancy, 1);
        tick();
        check("to_close_pulse", close_gate, 0);

        // Fill the lot; further arrivals are ignored.
        admit_car();
        check("full_occ", occupancy, 2);
        check("full_flag", lot_full, 1);
        sensor_1 = 1'b1;
        tick(); tick();
        sensor_1 = 1'b0;
        try_pin(PIN);
        check("full_ignored_open", open_gate, 0);
        car_exit = 1'b1;
        tick();
        car_exit = 1'b0;
        check("exit_occ", occupancy, 1);
        check("exit_full", lot_full, 0);

        // Pass and exit in the same cycle cancel out.
        enter_pin_entry();
        try_pin(PIN);
        sensor_2 = 1'b1; car_exit = 1'b1;
        tick();
        sensor_2 = 1'b0; car_exit = 1'b0;
        check("both_close", close_gate, 1);
        check("both_occ", occupancy, 1);

        // Exit saturates at zero.
        car_exit = 1'b1;
        tick();
        check("exit_to_0", occupancy, 0);
        tick();
        car_exit = 1'b0;
        check("exit_sat_0", occupancy, 0);

        // Reset during GATE_OPEN clears everything.
        admit_car();
        enter_pin_entry();
        try_pin(PIN);
        check("pre_rst_open", open_gate, 1);
        check("pre_rst_occ", occupancy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_open", open_gate, 0);
        check("mid_rst_close", close_gate, 0);
        check("mid_rst_occ", occupancy, 0);

        // Reset also clears BLOCKED.
        sensor_1 = 1'b1; sensor_2 = 1'b1;
        tick();
        sensor_1 = 1'b0; sensor_2 = 1'b0;
        check("idle_blk_alarm_2", alarm_2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("blk_rst_alarm_2", alarm_2, 0);
        enter_pin_entry();
        try_pin(PIN);
        check("post_rst_open", open_gate, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl_param.md
Name: parking_gate_ctrl_param

Overview:
Parametrised next-generation parking entry controller: PIN-authorised gate with configurable PIN width/value and attempt limit. Adds a gate-open timeout and a lot occupancy counter with a full flag. Sits between the entry sensors/keypad front-end and the barrier actuator driver. Single clock domain.

Parameters:
PIN_W, 8, PIN width in bits
PIN_VAL, 8'd87, authorised PIN (PIN_W bits)
MAX_TRIES, 3, wrong attempts before alarm_pin asserts (>=1)
CAPACITY, 16, lot capacity in cars (>=1)
OPEN_TO, 200, cycles gate may stay open without a car passing (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
sensor_1  in  1  car present at entry
sensor_2  in  1  car has passed the gate
try_psswrd  in  1  single-cycle strobe: evaluate psswrd_atmpt
psswrd_atmpt  in  PIN_W  PIN attempt
car_exit  in  1  single-cycle strobe: a car left the lot
alarm_1  out  1  wrong-PIN alarm (attempt limit reached)
alarm_2  out  1  block alarm (tailgate/sensor conflict)
open_gate  out  1  gate open command (level)
close_gate  out  1  gate close command (1-cycle pulse)
lot_full  out  1  occupancy == CAPACITY
occupancy  out  $clog2(CAPACITY+1)  cars currently inside

Behaviour:
- One clock; reset synchronous, active-high. All outputs registered (Moore-style), visible the cycle after the causing input.
- Reset: state IDLE; alarm_1, alarm_2, open_gate, close_gate, lot_full = 0; occupancy = 0; attempt counter = 0; timeout counter = 0. Reset mid-operation aborts anything in progress, including BLOCKED.
- States: IDLE, PIN_ENTRY, GATE_OPEN, BLOCKED.
- Global priority (every state except BLOCKED): sensor_1 && sensor_2 -> BLOCKED, alarm_2=1, open_gate=0. Beats try_psswrd in the same cycle.
- IDLE: sensor_1 && !lot_full -> PIN_ENTRY. sensor_1 while lot_full -> stay IDLE.
- PIN_ENTRY, on try_psswrd:
  - Correct PIN -> GATE_OPEN; open_gate=1; attempts=0; alarm_1=0; timeout=0.
  - Wrong PIN -> attempts+1, saturating at MAX_TRIES. alarm_1=1 when attempts reaches MAX_TRIES; it stays set until a correct PIN or reset. Further attempts are still evaluated.
- PIN_ENTRY without try_psswrd: hold. Dropping sensor_1 does not abort.
- GATE_OPEN: timeout counter increments each cycle.
  - sensor_2 -> close_gate pulse (1 cycle), open_gate=0, occupancy+1, -> IDLE.
  - Timeout reaching OPEN_TO-1 with no sensor_2 -> close_gate pulse, open_gate=0, occupancy unchanged, -> IDLE.
  - sensor_2 on the timeout cycle counts as a pass.
- BLOCKED: only try_psswrd with the correct PIN exits -> IDLE; alarm_2=0, alarm_1=0, attempts=0. Wrong PIN: stay, no counting. Sensors ignored.
- Occupancy:
  - car_exit decrements, saturating at 0.
  - Entry increment and car_exit in the same cycle -> net unchanged.
  - Increment never exceeds CAPACITY.
  - lot_full = (occupancy == CAPACITY), registered alongside occupancy.
  - car_exit is honoured in every state, including BLOCKED.
- close_gate is 0 in every cycle except the single pulse cycle.

Decomposition:
- Shared package parking_pkg: state enum (IDLE, PIN_ENTRY, GATE_OPEN, BLOCKED), default PIN constant, width helper for occupancy.
- One natural sub-module: parking_occupancy_ctr. Holds the saturating up/down counter plus lot_full. Inputs: clk, rst, inc, dec. Parameter: CAPACITY.
- FSM, attempt counter and timeout stay in the top module.

Test Plan:
- Reset, sensor_1=1, try_psswrd with 87 -> PIN_ENTRY, then open_gate=1 next cycle; sensor_2=1 -> close_gate pulses 1 cycle, occupancy=1, state IDLE.
- Three wrong PINs (e.g. 5) with MAX_TRIES=3 -> alarm_1=1 after the third; correct PIN -> alarm_1=0, open_gate=1.
- In GATE_OPEN assert sensor_1 && sensor_2 -> alarm_2=1, open_gate=0; wrong PIN keeps alarm_2=1; PIN 87 -> alarm_2=0, state IDLE, occupancy unchanged.
- Open gate, no sensor_2 for OPEN_TO cycles -> close_gate pulse at cycle OPEN_TO, occupancy unchanged.
- CAPACITY=2: admit 2 cars -> lot_full=1; sensor_1 ignored (stays IDLE); car_exit -> occupancy=1, lot_full=0; car_exit at 0 keeps occupancy=0.
- Entry pass and car_exit in the same cycle -> occupancy unchanged. rst during GATE_OPEN -> all outputs 0 next cycle.
